sum_seq_ctrl: RTL and testbench

Sequencing controller for a multi-cycle N-operand integer sum. It captures N unsigned operands on a start handshake and time-shares a bank of LANES two-input adders over K cycles. The first phase accumulates operands into per-lane partial sums; the second runs a halving reduction tree across the lanes. It sits in front of the lane adder bank and replaces the hand-unrolled per-(N,K) sequencing with one parameterized FSM.

---
 rtl/sum_pkg.sv | 28 ++
 rtl/sum_seq_ctrl_if.sv | 29 ++
 rtl/sum_lane_bank.sv | 19 +
 rtl/sum_seq_ctrl.sv | 158 +++++++++++++++
 tb/tb_sum_seq_ctrl.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/sum_pkg.sv
// Shared types and elaboration-time helpers for the multi-cycle N-operand summer.
package sum_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      REDUCE = 2'd2,
      DONE   = 2'd3
   } state_t;

   function automatic int clog2_int(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) begin
         r = r + 1;
      end
      return r;
   endfunction

   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

   function automatic int result_width(input int n, input int w);
      return w + clog2_int(n);
   endfunction

endpackage

// File: rtl/sum_seq_ctrl_if.sv
// Request/result bundle between a requester and the sum sequencer.
interface sum_seq_ctrl_if #(
   parameter int N = 50,
   parameter int W = 5
) ();
   localparam int RW = sum_pkg::result_width(N, W);

   logic            start;
   logic [N*W-1:0]  nums;
   logic            busy;
   logic            done;
   logic [RW-1:0]   sum;

   modport master (
      output start,
      output nums,
      input  busy,
      input  done,
      input  sum
   );

   modport slave (
      input  start,
      input  nums,
      output busy,
      output done,
      output sum
   );
endinterface

// File: rtl/sum_lane_bank.sv
// Bank of LANES independent two-input adders; operand selection lives in the controller.
module sum_lane_bank #(
   parameter int LANES = 8,
   parameter int RW    = 11
) (
   input  logic [LANES-1:0][RW-1:0] i_a,
   input  logic [LANES-1:0][RW-1:0] i_b,
   output logic [LANES-1:0][RW-1:0] o_sum
);

   // One adder per lane, no carry between lanes
   always_comb begin
      o_sum = '0;
      for (int i = 0; i < LANES; i++) begin
         o_sum[i] = i_a[i] + i_b[i];
      end
   end

endmodule

// File: rtl/sum_seq_ctrl.sv
// Sequences an N-operand sum over a shared adder bank: CA accumulate cycles
// followed by CR halving-reduction cycles, result registered on entry to DONE.
module sum_seq_ctrl
   import sum_pkg::*;
#(
   parameter int N     = 50,
   parameter int W     = 5,
   parameter int LANES = 8
) (
   input  logic          clk,
   input  logic          rst,
   sum_seq_ctrl_if.slave bus
);

   localparam int CA   = ceil_div(N, LANES);
   localparam int CR   = clog2_int(LANES);
   localparam int RW   = result_width(N, W);
   localparam int CNTW = clog2_int(CA + CR + 1);
   localparam logic [CNTW-1:0] CA_LAST = CNTW'(CA - 1);
   localparam logic [CNTW-1:0] CR_LAST = CNTW'(CR - 1);

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic [CNTW-1:0]           r_cnt;
   logic [CNTW-1:0]           w_cnt_nxt;
   logic [N*W-1:0]            r_ops;
   logic [LANES-1:0][RW-1:0]  r_acc;
   logic [LANES-1:0][RW-1:0]  w_a;
   logic [LANES-1:0][RW-1:0]  w_b;
   logic [LANES-1:0][RW-1:0]  w_sum;
   logic [LANES-1:0]          w_we;
   logic                      w_load;
   logic                      r_busy;
   logic                      r_done;
   logic [RW-1:0]             r_sum;
   int                        w_idx;

   sum_lane_bank #(
      .LANES (LANES),
      .RW    (RW)
   ) u_lane_bank (
      .i_a   (w_a),
      .i_b   (w_b),
      .o_sum (w_sum)
   );

   // Next-state, counter and adder operand steering
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_load      = 1'b0;
      w_a         = '0;
      w_b         = '0;
      w_we        = '0;
      w_idx       = 0;
      case (r_state)
         IDLE, DONE: begin
            if (bus.start) begin
               w_load      = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = ACCUM;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         ACCUM: begin
            for (int i = 0; i < LANES; i++) begin
               w_idx  = int'(r_cnt) * LANES + i;
               w_a[i] = r_acc[i];
               if (w_idx < N) begin
                  w_b[i] = RW'(r_ops[w_idx*W +: W]);
               end else begin
                  w_b[i] = '0;
               end
            end
            w_we = '1;
            if (r_cnt == CA_LAST) begin
               w_cnt_nxt   = '0;
               w_state_nxt = (CR == 0) ? DONE : REDUCE;
            end else begin
               w_cnt_nxt = r_cnt + CNTW'(1);
            end
         end
         REDUCE: begin
            // Lane i folds the pair (2i, 2i+1); active lanes halve every cycle
            for (int i = 0; i < LANES / 2; i++) begin
               w_a[i] = r_acc[2*i];
               w_b[i] = r_acc[2*i+1];
               if (i < (LANES >> (int'(r_cnt) + 1))) begin
                  w_we[i] = 1'b1;
               end else begin
                  w_we[i] = 1'b0;
               end
            end
            if (r_cnt == CR_LAST) begin
               w_cnt_nxt   = '0;
               w_state_nxt = DONE;
            end else begin
               w_cnt_nxt = r_cnt + CNTW'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // State, counter and operand capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_ops   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_load) begin
            r_ops <= bus.nums;
         end
      end
   end

   // Per-lane accumulators, cleared on an accepted start
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc <= '0;
      end else if (w_load) begin
         r_acc <= '0;
      end else begin
         for (int i = 0; i < LANES; i++) begin
            if (w_we[i]) begin
               r_acc[i] <= w_sum[i];
            end
         end
      end
   end

   // Outputs are decoded from the next state so they align with the state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_sum  <= '0;
      end else begin
         r_busy <= (w_state_nxt == ACCUM) || (w_state_nxt == REDUCE);
         r_done <= (w_state_nxt == DONE);
         if (w_state_nxt == DONE) begin
            r_sum <= w_sum[0];
         end
      end
   end

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.sum  = r_sum;

endmodule

// File: tb/tb_sum_seq_ctrl.sv
// Directed, table-driven bench for sum_seq_ctrl: default build plus two edge configurations.
module tb_sum_seq_ctrl;
   import sum_pkg::*;

   localparam int N0  = 50;
   localparam int W0  = 5;
   localparam int RW0 = result_width(N0, W0);

   typedef struct {
      logic [N0*W0-1:0] nums;
      int               exp_sum;
      int               mode;     // 0 plain, 1 scramble nums while busy, 2 hold start high
   } vec_t;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_fail;
   vec_t vecs [6];

   sum_seq_ctrl_if #(.N(50), .W(5)) bus0 ();
   sum_seq_ctrl_if #(.N(3),  .W(5)) bus1 ();
   sum_seq_ctrl_if #(.N(4),  .W(5)) bus2 ();

   sum_seq_ctrl #(.N(50), .W(5), .LANES(8)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
   sum_seq_ctrl #(.N(3),  .W(5), .LANES(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
   sum_seq_ctrl #(.N(4),  .W(5), .LANES(1)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_cmp = n_cmp + 1;
      if (act != exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [N0*W0-1:0] fill_const(input logic [W0-1:0] v);
      logic [N0*W0-1:0] r;
      for (int k = 0; k < N0; k++) r[k*W0 +: W0] = v;
      return r;
   endfunction

   // Called at a negedge with start already driven; returns at the negedge where done is seen.
   task automatic wait_done(input int mode, output int lat, output int bcnt);
      lat  = 0;
      bcnt = 0;
      @(posedge clk);
      while (1) begin
         @(negedge clk);
         if (mode != 2) bus0.start = 1'b0;
         if (mode == 1) begin
            for (int k = 0; k < N0; k++) bus0.nums[k*W0 +: W0] = W0'($urandom);
         end
         if (bus0.done) begin
            bus0.start = 1'b0;
            break;
         end
         if (bus0.busy) bcnt = bcnt + 1;
         lat = lat + 1;
         if (lat > 40) begin
            check("timeout_done", lat, 10);
            break;
         end
      end
   endtask

   task automatic run_vec(input int idx);
      int lat;
      int bcnt;
      bus0.nums  = vecs[idx].nums;
      bus0.start = 1'b1;
      wait_done(vecs[idx].mode, lat, bcnt);
      check($sformatf("v%0d_latency", idx), lat, 10);
      check($sformatf("v%0d_busy_cycles", idx), bcnt, 10);
      check($sformatf("v%0d_sum", idx), int'(bus0.sum), vecs[idx].exp_sum);
      check($sformatf("v%0d_busy_at_done", idx), int'(bus0.busy), 0);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", idx), int'(bus0.done), 0);
      check($sformatf("v%0d_busy_after", idx), int'(bus0.busy), 0);
      check($sformatf("v%0d_sum_held", idx), int'(bus0.sum), vecs[idx].exp_sum);
   endtask

   initial begin
      int lat;
      int bcnt;
      logic [N0*W0-1:0] pat;
      n_cmp  = 0;
      n_fail = 0;

      pat = '0;
      for (int k = 0; k < N0; k++) pat[k*W0 +: W0] = W0'((k + 1) % 32);
      vecs[0] = '{nums: fill_const(5'd31), exp_sum: 1550, mode: 0};
      vecs[1] = '{nums: pat,               exp_sum: 667,  mode: 1};
      vecs[2] = '{nums: pat,               exp_sum: 667,  mode: 0};
      vecs[3] = '{nums: fill_const(5'd31), exp_sum: 1550, mode: 2};
      vecs[4] = '{nums: '0,                exp_sum: 775,  mode: 0};
      for (int k = 1; k < N0; k += 2) vecs[4].nums[k*W0 +: W0] = 5'd31;
      vecs[5] = '{nums: '0,                exp_sum: 0,    mode: 0};

      rst        = 1'b1;
      bus0.start = 1'b0;
      bus0.nums  = '0;
      bus1.start = 1'b0;
      bus1.nums  = '0;
      bus2.start = 1'b0;
      bus2.nums  = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", int'(bus0.busy), 0);
      check("rst_done", int'(bus0.done), 0);
      check("rst_sum", int'(bus0.sum), 0);
      check("rst_sum_n3", int'(bus1.sum), 0);
      check("rst_busy_l1", int'(bus2.busy), 0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 6; i++) run_vec(i);

      // Back-to-back: second start issued in the DONE cycle
      bus0.nums  = fill_const(5'd31);
      bus0.start = 1'b1;
      wait_done(0, lat, bcnt);
      check("b2b_first_sum", int'(bus0.sum), 1550);
      bus0.nums  = fill_const(5'd1);
      bus0.start = 1'b1;
      wait_done(0, lat, bcnt);
      check("b2b_latency", lat, 10);
      check("b2b_busy_no_gap", bcnt, 10);
      check("b2b_second_sum", int'(bus0.sum), 50);
      @(negedge clk);

      // Asynchronous reset four cycles into ACCUM, then a clean rerun
      bus0.nums  = pat;
      bus0.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus0.start = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_busy", int'(bus0.busy), 0);
      check("midrst_done", int'(bus0.done), 0);
      check("midrst_sum", int'(bus0.sum), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_vec(2);

      // N=3, LANES=4: one accumulate cycle then two reduce cycles
      bus1.nums  = {5'd31, 5'd31, 5'd31};
      bus1.start = 1'b1;
      @(posedge clk);
      lat = 0;
      while (1) begin
         @(negedge clk);
         bus1.start = 1'b0;
         if (bus1.done || lat > 20) break;
         lat = lat + 1;
      end
      check("n3_latency", lat, 3);
      check("n3_sum", int'(bus1.sum), 93);

      // N=4, LANES=1: four accumulate cycles, no reduction
      bus2.nums  = {5'd4, 5'd3, 5'd2, 5'd1};
      bus2.start = 1'b1;
      @(posedge clk);
      lat = 0;
      while (1) begin
         @(negedge clk);
         bus2.start = 1'b0;
         if (bus2.done || lat > 20) break;
         lat = lat + 1;
      end
      check("l1_latency", lat, 4);
      check("l1_sum", int'(bus2.sum), 10);
      @(negedge clk);
      check("l1_done_pulse", int'(bus2.done), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
